i_cache: RTL and testbench

Direct-mapped instruction cache between the fetch stage and the 128-bit block instruction memory. Fetch presents a 32-bit byte PC and gets a 32-bit instruction on a hit, or a stall while the cache fills. On a miss the cache acts as the read initiator on the memory interface: it drives block address and read enable, waits out the memory busywait, then writes the 16-byte block.

---
 rtl/i_cache.sv | 113 +++++++++++
 tb/tb_i_cache.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache.sv
// Direct-mapped 8-line instruction cache that fills 128-bit blocks from instruction memory on a miss.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
module i_cache #(
  parameter int SETS = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         CPU_BUSYWAIT,
  output logic         MEM_READ_EN,
  output logic [27:0]  MEM_READ_ADDR,
  input  logic         MEM_BUSYWAIT,
  input  logic [127:0] MEM_READ_DATA
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [SETS-1:0] valid;
  logic [24:0]     tag_arr  [SETS];
  logic [127:0]    data_arr [SETS];
  logic [27:0]     miss_addr;

  logic [24:0] pc_tag;
  logic [2:0]  pc_index;
  logic [1:0]  pc_word;
  logic        hit;
  logic [31:0] sel_word;
  logic        unused_pc_bits;

  assign pc_tag         = PC[31:7];
  assign pc_index       = PC[6:4];
  assign pc_word        = PC[3:2];
  assign unused_pc_bits = ^PC[1:0];

  assign hit = (state == IDLE) && valid[pc_index] && (tag_arr[pc_index] == pc_tag);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!hit) next_state = MEM_READ;
      MEM_READ: if (!MEM_BUSYWAIT) next_state = UPDATE;
      UPDATE:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    case (pc_word)
      2'd0:    sel_word = data_arr[pc_index][31:0];
      2'd1:    sel_word = data_arr[pc_index][63:32];
      2'd2:    sel_word = data_arr[pc_index][95:64];
      default: sel_word = data_arr[pc_index][127:96];
    endcase
  end

  always_comb begin
    MEM_READ_EN   = (state == MEM_READ);
    MEM_READ_ADDR = miss_addr;
    CPU_BUSYWAIT  = !hit;
    INSTRUCTION   = hit ? sel_word : 32'h0;
  end

  // The fill address is captured once so a PC change mid-fill cannot redirect the request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      miss_addr <= 28'h0;
      valid     <= '0;
    end else begin
      if (state == IDLE && !hit) miss_addr <= PC[31:4];
      if (state == UPDATE)       valid[miss_addr[2:0]] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the cleared valid bits make them don't-care.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      tag_arr[miss_addr[2:0]]  <= miss_addr[27:3];
      data_arr[miss_addr[2:0]] <= MEM_READ_DATA;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HIT_COUNT  <= 32'h0;
      MISS_COUNT <= 32'h0;
    end else if (state == IDLE) begin
      if (hit) HIT_COUNT  <= HIT_COUNT + 32'd1;
      else     MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: directed test-plan scenarios then randomized PCs against a
// behavioural model of the cache (valid/tag table plus a fill-progress counter).
module tb_i_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         CPU_BUSYWAIT;
  logic         MEM_READ_EN;
  logic [27:0]  MEM_READ_ADDR;
  logic         MEM_BUSYWAIT;
  logic [127:0] MEM_READ_DATA;
`ifdef ICACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  i_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PC            (PC),
    .INSTRUCTION   (INSTRUCTION),
    .CPU_BUSYWAIT  (CPU_BUSYWAIT),
    .MEM_READ_EN   (MEM_READ_EN),
    .MEM_READ_ADDR (MEM_READ_ADDR),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .MEM_READ_DATA (MEM_READ_DATA)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: block 0 holds 0x11,0x22,0x33,0x44; other blocks a hash.
  function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
    logic [31:0] x;
    if (blk == 28'h0) return 32'h11 * ({30'd0, w} + 32'd1);
    x = {2'b00, blk, w};
    return (x * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] blk);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[32*w +: 32] = mem_word(blk, w[1:0]);
    return b;
  endfunction

  // Memory model: busy for cur_lat cycles of a request, block latched on the completing edge.
  int   cur_lat    = 15;
  int   mem_cnt    = 0;
  logic idle_noise = 1'b0;

  assign MEM_BUSYWAIT = MEM_READ_EN ? (mem_cnt < cur_lat) : idle_noise;

  always @(posedge CLK) begin
    if (MEM_READ_EN) begin
      mem_cnt <= mem_cnt + 1;
      if (mem_cnt >= cur_lat) MEM_READ_DATA <= mem_block(MEM_READ_ADDR);
    end else begin
      mem_cnt       <= 0;
      MEM_READ_DATA <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Reference model: fill_k = -1 when idle, else cycles since the miss (1..lat+1 reading, lat+2 update).
  bit          m_valid [8];
  logic [24:0] m_tag   [8];
  int          fill_k    = -1;
  int          fill_lat  = 0;
  int          fixed_lat = 15;
  logic [27:0] fill_addr = '0;
  logic [31:0] m_hits    = 0;
  logic [31:0] m_misses  = 0;
  logic        last_busy;

  function automatic bit model_hit(input logic [31:0] pc);
    return (fill_k < 0) && m_valid[pc[6:4]] && (m_tag[pc[6:4]] == pc[31:7]);
  endfunction

  task automatic cycle();
    bit hit;
    bit exp_en;
    @(negedge CLK);
    hit       = model_hit(PC);
    exp_en    = (fill_k >= 1) && (fill_k <= fill_lat + 1);
    last_busy = CPU_BUSYWAIT;
    check("busywait", {31'd0, CPU_BUSYWAIT}, {31'd0, !hit});
    check("instr", INSTRUCTION, hit ? mem_word(PC[31:4], PC[3:2]) : 32'h0);
    check("rd_en", {31'd0, MEM_READ_EN}, {31'd0, exp_en});
    if (exp_en) check("rd_addr", {4'd0, MEM_READ_ADDR}, {4'd0, fill_addr});
`ifdef ICACHE_STATS_EN
    check("hit_count", HIT_COUNT, m_hits);
    check("miss_count", MISS_COUNT, m_misses);
`endif
    @(posedge CLK);
    if (fill_k < 0) begin
      if (hit) m_hits++;
      else begin
        m_misses++;
        fill_k    = 1;
        fill_addr = PC[31:4];
        fill_lat  = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 15);
        cur_lat   = fill_lat;
      end
    end else if (fill_k == fill_lat + 2) begin
      m_valid[fill_addr[2:0]] = 1'b1;
      m_tag[fill_addr[2:0]]   = fill_addr[27:3];
      fill_k = -1;
    end else begin
      fill_k++;
    end
    #1;
    idle_noise = 1'($urandom);
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    #1;
    check("rst_rd_en", {31'd0, MEM_READ_EN}, 32'd0);
    check("rst_rd_addr", {4'd0, MEM_READ_ADDR}, 32'd0);
    check("rst_busy", {31'd0, CPU_BUSYWAIT}, 32'd1);
    check("rst_instr", INSTRUCTION, 32'h0);
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    fill_k   = -1;
    m_hits   = 0;
    m_misses = 0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic run_until_hit(input string tag);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (last_busy && n < 100);
    check(tag, {31'd0, last_busy}, 32'd0);
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    PC    = 32'h0;
    #2;
    apply_reset();

    // Cold miss with a 15-busy-cycle memory: 18 stalled cycles, then 0x11.
    fixed_lat = 15;
    PC = 32'h0;
    n  = 0;
    do begin
      cycle();
      if (last_busy) n++;
    end while (last_busy && n < 100);
    check("cold_stall", n, 32'd18);

    // Same-block hits.
    PC = 32'h4;  cycle(); check("hit_pc4", INSTRUCTION, 32'h22);
    PC = 32'h8;  cycle(); check("hit_pc8", INSTRUCTION, 32'h33);
    PC = 32'hC;  cycle(); check("hit_pc12", INSTRUCTION, 32'h44);
`ifdef ICACHE_STATS_EN
    check("stat_hits", HIT_COUNT, 32'd4);
    check("stat_misses", MISS_COUNT, 32'd1);
`endif

    // Conflict: 0x80 evicts line 0, so PC=0 misses again.
    fixed_lat = 3;
    PC = 32'h80;
    cycle();
    cycle(); check("conflict_addr", {4'd0, MEM_READ_ADDR}, 32'h8);
    run_until_hit("conflict_fill");
    PC = 32'h0;
    cycle(); check("conflict_remiss", {31'd0, last_busy}, 32'd1);
    run_until_hit("refill_0");

    // PC change mid-fill: line 1 is filled from 28'h1, then 0x20 fills from 28'h2.
    PC = 32'h10;
    cycle();
    PC = 32'h20;
    cycle(); check("midfill_addr", {4'd0, MEM_READ_ADDR}, 32'h1);
    run_until_hit("midfill_second");
    PC = 32'h14;
    cycle(); check("midfill_line1", {31'd0, last_busy}, 32'd0);

    // Memory already done on the first MEM_READ cycle.
    fixed_lat = 0;
    PC = 32'h30;
    run_until_hit("zero_lat_fill");

    // Reset in the middle of a fill.
    fixed_lat = 15;
    PC = 32'h40;
    cycle();
    cycle(); check("midfill_en", {31'd0, MEM_READ_EN}, 32'd1);
    apply_reset();
    PC = 32'h0;
    cycle(); check("post_rst_miss", {31'd0, last_busy}, 32'd1);
    run_until_hit("post_rst_fill");

    // Randomized PCs over three tags so hits, conflicts and mid-fill PC changes all occur.
    fixed_lat = -1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) != 0)
        PC = {25'($urandom_range(0, 2)), 3'($urandom), 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 799) == 0) apply_reset();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
